// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan code decoder: folds E0/F0/E1 prefix sequences into single
// {extended, release, code} key events. It can suppress typematic repeats and
// queues the events in a first-word-fall-through FIFO with valid/ready.
module ps2_scancode_decoder #(
    parameter int DEPTH          = 8,
    parameter int FILTER_REPEAT  = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     inclock,
    input  logic                     resetn,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     evt_ready,
    input  logic                     clr_overflow,
    output logic                     evt_valid,
    output logic [7:0]               evt_code,
    output logic                     evt_ext,
    output logic                     evt_rel,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     any_key_held
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_t;

    state_t        state, state_n;
    logic [2:0]    skip_cnt, skip_n;
    logic [TW-1:0] tmo_cnt, tmo_n;

    logic          emit, emit_ext, emit_rel, emit_pause;
    logic [7:0]    emit_code;
    logic [8:0]    held_idx;
    logic [511:0]  held;
    logic          push, pop, push_ok, full;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [9:0]    head;

    // Keyboard housekeeping bytes (BAT result, ACK, resend, echo, errors).
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // Fake shift codes that some keyboards wrap around extended keys.
    function automatic logic is_fake_shift(input logic [7:0] b);
        return (b == 8'h12) || (b == 8'h59);
    endfunction

    // Decoder state, pause skip count and prefix timeout counter.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
            tmo_cnt  <= tmo_n;
        end
    end

    // Prefix decoding: next state, timeout and the event emitted this cycle.
    always_comb begin
        state_n    = state;
        skip_n     = skip_cnt;
        tmo_n      = '0;
        emit       = 1'b0;
        emit_ext   = 1'b0;
        emit_rel   = 1'b0;
        emit_pause = 1'b0;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_n = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_n = S_BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_n = S_PAUSE;
                        skip_n  = 3'd7;
                    end else if (!is_ignored(rx_data)) begin
                        emit = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_n = S_EXTBRK;
                    end else if (rx_data != 8'hE0) begin
                        state_n = S_IDLE;
                        if (!is_fake_shift(rx_data)) begin
                            emit     = 1'b1;
                            emit_ext = 1'b1;
                        end
                    end
                end
                S_BRK: begin
                    state_n  = S_IDLE;
                    emit     = 1'b1;
                    emit_rel = 1'b1;
                end
                S_EXTBRK: begin
                    state_n = S_IDLE;
                    if (!is_fake_shift(rx_data)) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_rel = 1'b1;
                    end
                end
                S_PAUSE: begin
                    skip_n = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        state_n    = S_IDLE;
                        emit       = 1'b1;
                        emit_ext   = 1'b1;
                        emit_pause = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
                state_n = S_IDLE;
            end else begin
                tmo_n = tmo_cnt + 1'b1;
            end
        end
    end

    // The pause event always carries E1, which is not the byte that ends it.
    assign emit_code = emit_pause ? 8'hE1 : rx_data;
    assign held_idx  = {emit_ext, rx_data};
    assign push      = emit && (emit_pause || emit_rel || (FILTER_REPEAT == 0) || !held[held_idx]);

    // Held-key bitmap tracks every make/break, even when the FIFO drops it.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            held         <= '0;
            any_key_held <= 1'b0;
        end else begin
            if (emit && !emit_pause) begin
                held[held_idx] <= !emit_rel;
            end
            any_key_held <= |held;
        end
    end

    assign full    = (count == (AW + 1)'(DEPTH));
    assign pop     = evt_valid && evt_ready;
    assign push_ok = push && (!full || pop);

    // Event storage; at full with a pop the slot being vacated is reused.
    always_ff @(posedge inclock) begin
        if (push_ok) begin
            mem[wr_ptr] <= {emit_ext, emit_rel, emit_code};
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign evt_valid  = (count != '0);
    assign fifo_level = count;
    assign evt_ext    = evt_valid && head[9];
    assign evt_rel    = evt_valid && head[8];
    assign evt_code   = evt_valid ? head[7:0] : 8'h00;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: a filtering instance and a pass-all instance
// share one byte stream; a reference decoder predicts their event queues.
module tb_ps2_scancode_decoder;

    localparam int TMO = 16;
    localparam int M_IDLE = 0, M_EXT = 1, M_BRK = 2, M_EXTBRK = 3, M_PAUSE = 4;

    logic       inclock = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       evt_ready = 1'b0;
    logic       clr_overflow = 1'b0;

    logic       evt_valid, evt_ext, evt_rel, overflow, any_key_held;
    logic [7:0] evt_code;
    logic [3:0] fifo_level;
    logic       b_valid, b_ext, b_rel, b_overflow, b_held;
    logic [7:0] b_code;
    logic [3:0] b_level;

    int checks = 0;
    int failures = 0;

    logic [9:0] qa[$];
    logic [9:0] qb[$];
    int         ms = M_IDLE;
    int         mskip = 0;
    int         mt = 0;
    bit [511:0] mheld = '0;
    bit         allow_a = 1'b1;

    ps2_scancode_decoder #(.DEPTH(8), .FILTER_REPEAT(1), .TIMEOUT_CYCLES(TMO)) u_dut (
        .inclock(inclock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .evt_ready(evt_ready), .clr_overflow(clr_overflow), .evt_valid(evt_valid),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_rel(evt_rel),
        .fifo_level(fifo_level), .overflow(overflow), .any_key_held(any_key_held)
    );

    ps2_scancode_decoder #(.DEPTH(8), .FILTER_REPEAT(0), .TIMEOUT_CYCLES(TMO)) u_nofilt (
        .inclock(inclock), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
        .evt_ready(1'b1), .clr_overflow(clr_overflow), .evt_valid(b_valid),
        .evt_code(b_code), .evt_ext(b_ext), .evt_rel(b_rel),
        .fifo_level(b_level), .overflow(b_overflow), .any_key_held(b_held)
    );

    always #5 inclock = ~inclock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pop-side scoreboards: compare each head as it is accepted.
    always @(negedge inclock) begin
        if (resetn === 1'b1) begin
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                chk("a_evt_expected", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) chk("a_evt", 32'({evt_ext, evt_rel, evt_code}), 32'(qa.pop_front()));
            end
            if (b_valid === 1'b1) begin
                chk("b_evt_expected", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) chk("b_evt", 32'({b_ext, b_rel, b_code}), 32'(qb.pop_front()));
            end
        end
    end

    task automatic model_reset();
        ms = M_IDLE; mskip = 0; mt = 0; mheld = '0;
        qa.delete(); qb.delete();
    endtask

    task automatic model_emit(input bit ext, input bit rel, input bit pause, input logic [7:0] code);
        logic [8:0] idx;
        idx = {ext, code};
        qb.push_back({ext, rel, code});
        if (pause || rel || !mheld[idx]) begin
            if (allow_a) qa.push_back({ext, rel, code});
        end
        if (!pause) mheld[idx] = !rel;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit fake;
        fake = (b == 8'h12) || (b == 8'h59);
        mt = 0;
        case (ms)
            M_IDLE: begin
                if (b == 8'hE0) ms = M_EXT;
                else if (b == 8'hF0) ms = M_BRK;
                else if (b == 8'hE1) begin ms = M_PAUSE; mskip = 7; end
                else if (!(b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE || b == 8'h00 || b == 8'hFF))
                    model_emit(1'b0, 1'b0, 1'b0, b);
            end
            M_EXT: begin
                if (b == 8'hF0) ms = M_EXTBRK;
                else if (b != 8'hE0) begin
                    ms = M_IDLE;
                    if (!fake) model_emit(1'b1, 1'b0, 1'b0, b);
                end
            end
            M_BRK: begin ms = M_IDLE; model_emit(1'b0, 1'b1, 1'b0, b); end
            M_EXTBRK: begin ms = M_IDLE; if (!fake) model_emit(1'b1, 1'b1, 1'b0, b); end
            default: begin
                mskip--;
                if (mskip == 0) begin ms = M_IDLE; model_emit(1'b1, 1'b0, 1'b1, 8'hE1); end
            end
        endcase
    endtask

    task automatic model_tick();
        if (ms != M_IDLE) begin
            if (mt == TMO - 1) begin ms = M_IDLE; mt = 0; end
            else mt++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        model_byte(b);
        @(posedge inclock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            model_tick();
            @(posedge inclock); #1;
        end
    endtask

    task automatic drain(input string tag);
        evt_ready = 1'b1;
        for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
        idle(2);
        chk({tag, "_qa_left"}, 32'(qa.size()), 32'd0);
        chk({tag, "_qb_left"}, 32'(qb.size()), 32'd0);
        chk({tag, "_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_empty_outs"}, 32'({evt_valid, evt_ext, evt_rel, evt_code}), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge inclock);
        #1;
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt", 32'({evt_ext, evt_rel, evt_code}), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_held", 32'(any_key_held), 32'd0);
        resetn = 1'b1;
        model_reset();
        evt_ready = 1'b1;

        // plain make/break
        send(8'h1C); idle(1);
        chk("t1_held_set", 32'(any_key_held), 32'd1);
        send(8'hF0); send(8'h1C); idle(1);
        chk("t1_held_clr", 32'(any_key_held), 32'd0);
        drain("t1");

        // extended keys with fake shifts
        send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h12);
        drain("t2");

        // typematic repeat
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'hF0); send(8'h1D);
        drain("t3");

        // pause sequence, then a normal make
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C);
        drain("t4");

        // FIFO fill, overflow, clear priority, push+pop at full
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            allow_a = (i < 8);
            send(8'(8'h01 + i));
        end
        allow_a = 1'b1;
        idle(1);
        chk("t5_level_full", 32'(fifo_level), 32'd8);
        chk("t5_overflow", 32'(overflow), 32'd1);
        chk("t5_head", 32'(evt_code), 32'h01);
        clr_overflow = 1'b1;
        allow_a = 1'b0;
        send(8'h0C);
        allow_a = 1'b1;
        clr_overflow = 1'b0;
        chk("t5_drop_beats_clr", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        send(8'h0B);
        evt_ready = 1'b0;
        chk("t5_pushpop_full", 32'(fifo_level), 32'd8);
        chk("t5_head_after_pop", 32'(evt_code), 32'h02);
        clr_overflow = 1'b1; idle(1); clr_overflow = 1'b0;
        chk("t5_overflow_clr", 32'(overflow), 32'd0);
        drain("t5");

        // prefix timeout: short gap keeps break, long gap abandons it
        send(8'hF0); idle(8); send(8'h1C);
        send(8'hF0); idle(20); send(8'h1C);
        drain("t6");

        // reset with queued events and a pending prefix
        evt_ready = 1'b0;
        send(8'h21); send(8'h22); send(8'h23); send(8'hE0); idle(1);
        chk("t7_level", 32'(fifo_level), 32'd3);
        chk("t7_held", 32'(any_key_held), 32'd1);
        resetn = 1'b0;
        @(posedge inclock); #1;
        chk("t7_rst_valid", 32'(evt_valid), 32'd0);
        chk("t7_rst_level", 32'(fifo_level), 32'd0);
        chk("t7_rst_held", 32'(any_key_held), 32'd0);
        resetn = 1'b1;
        model_reset();
        evt_ready = 1'b1;
        send(8'h1C);
        drain("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Consumes the raw byte stream from the PS/2 receiver (8-bit data plus 1-cycle valid strobe). Decodes Set-2 prefix sequences (E0 extended, F0 break, E1 Pause) into single key events {extended, release, code}. Optionally suppresses typematic auto-repeat makes. Buffers events in a first-word-fall-through FIFO with a valid/ready handshake for game/display logic downstream.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
FILTER_REPEAT, 1, 1 = drop a make for a key already held; 0 = pass every make
TIMEOUT_CYCLES, 1000000, idle cycles in a prefix state before abandoning the sequence (20 ms at 50 MHz)

Ports:
inclock  in  1  clock
resetn  in  1  reset; synchronous, active-low
rx_data  in  8  received byte from PS/2 receiver
rx_valid  in  1  1-cycle strobe; rx_data valid this cycle
evt_ready  in  1  consumer accepts head event
clr_overflow  in  1  clears sticky overflow
evt_valid  out  1  FIFO non-empty
evt_code  out  8  head event scan code
evt_ext  out  1  head event extended (E0/E1)
evt_rel  out  1  head event is break
fifo_level  out  $clog2(DEPTH)+1  occupied entries
overflow  out  1  sticky: an event was dropped
any_key_held  out  1  held-key bitmap non-zero

Behaviour:
- Reset (resetn=0 at clock edge) clears:
  - FSM to IDLE, FIFO empty, held bitmap (512 bits, index {ext,code}), timeout counter.
  - All outputs 0: evt_valid, evt_code, evt_ext, evt_rel, fifo_level, overflow, any_key_held.
  - Applies mid-sequence and mid-FIFO; any partial event is discarded.
- Decoder FSM; acts only on cycles with rx_valid=1:
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7.
    - AA, FA, FE, EE, 00, FF are discarded; stay IDLE.
    - Any other byte b: emit {0,0,b}; stay IDLE.
  - EXT:
    - F0 -> EXTBRK; E0 -> stay EXT.
    - 12 or 59 (fake shift) is discarded -> IDLE.
    - Other b: emit {1,0,b} -> IDLE.
  - BRK: any b -> emit {0,1,b} -> IDLE.
  - EXTBRK:
    - 12 or 59 is discarded -> IDLE.
    - Other b: emit {1,1,b} -> IDLE.
  - PAUSE:
    - Discard bytes, decrementing skip count.
    - On the 7th discarded byte: emit {1,0,E1} -> IDLE. Pause has no break event.
- Timeout:
  - In EXT/BRK/EXTBRK/PAUSE the counter increments each cycle without rx_valid.
  - Counter resets on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1, FSM -> IDLE with no emit.
  - Counter is held at 0 in IDLE.
- Held bitmap and repeat filter:
  - A make sets bit {ext,code}; a break clears it.
  - The bitmap updates whether or not the FIFO accepts the event.
  - FILTER_REPEAT=1: a make whose bit is already set is not pushed. Breaks are always pushed. The Pause event is never filtered and never sets a bit.
  - any_key_held is registered from the bitmap; it reflects an update 1 cycle after the bitmap changes.
- Latency: an event emitted on rx_valid edge N is pushed at edge N. evt_valid/evt_* are visible after edge N when the FIFO was empty (1 cycle from strobe).
- FIFO, first-word fall-through:
  - evt_* always show the head entry.
  - Pop when evt_valid & evt_ready at a clock edge.
  - Push and pop in the same cycle: level unchanged. This is legal at full and at empty+1.
  - Push when full with no pop: event dropped, overflow<=1.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- overflow is cleared by clr_overflow=1. A drop in the same cycle as clr_overflow wins (overflow=1).
- evt_* are 0 when the FIFO is empty.

Test Plan:
- Plain key: strobe 1C, then F0,1C with evt_ready=1 -> events {0,0,1C} then {0,1,1C}; any_key_held goes 1 then 0; fifo_level returns to 0.
- Extended + fake shift: E0,12,E0,75,E0,F0,75,E0,F0,12 -> exactly {1,0,75},{1,1,75}; no 12 events.
- Repeat filter (FILTER_REPEAT=1): 1D,1D,1D,F0,1D -> {0,0,1D},{0,1,1D} only. With FILTER_REPEAT=0 -> four events.
- Pause: E1,14,77,E1,F0,14,F0,77 -> single {1,0,E1}; FSM IDLE afterwards (next 1C yields {0,0,1C}).
- FIFO stress, DEPTH=8, evt_ready=0: 10 distinct makes -> fifo_level=8, overflow=1, first 8 codes retained in order. Push+pop at full keeps level 8. clr_overflow -> overflow=0.
- Timeout/reset: F0 then silence of TIMEOUT_CYCLES (set to 16) -> IDLE; next 1C gives make, not break. resetn=0 with 3 queued events -> evt_valid=0, fifo_level=0, any_key_held=0 next cycle.
